// File: rtl/tt_binclk_pkg.sv
// rtl/tt_binclk_pkg.sv - shared limits, widths and time record for the binary wall clock
// Purpose: modulo limits and field widths for the sec/min/hour counters, and
//          a packed record of the clock time used by the top level.
// Ports:   none (package)
package tt_binclk_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } bin_time_t;

endpackage

// File: rtl/tt11_um_oblivioux_mod_counter.sv
// rtl/tt11_um_oblivioux_mod_counter.sv - modulo-(MAX+1) counter with carry-out
// Purpose: counts 0..MAX, wrapping to 0; clr forces 0 and wins over inc.
// Ports:   clk, rst (sync, active-high), inc (advance), clr (force zero),
//          q (count), wrap (inc while q==MAX, i.e. carry to next stage)
module mod_counter
  import tt_binclk_pkg::*;
#(
  parameter int MAX = SEC_MAX,
  parameter int W   = SEC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic at_max;

  assign at_max = (q == W'(MAX));
  assign wrap   = inc & at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/tt11_um_oblivioux.sv
// rtl/tt11_um_oblivioux.sv - Tiny Tapeout tile: 24-hour binary wall clock HH:MM:SS
// Purpose: prescaler divides clk to a 1 Hz tick; chained modulo counters hold
//          sec/min/hour; buttons on ui_in set the time.
// Ports:   clk, rst (sync, active-high), ena (ignored),
//          ui_in  [0] run, [1] min-set, [2] hour-set, [3] fast, [7] display select
//          uo_out [5:0] minutes (or seconds), [6] seconds[0], [7] 0
//          uio_in unused; uio_out [4:0] hours; uio_oe constant 8'h1F
// Option:  DISPLAY_SEL_EN - when defined, synced ui_in[7]=1 shows seconds on uo_out[5:0]
module tt11_um_oblivioux
  import tt_binclk_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = $clog2(CLK_HZ);

  // Two-flop synchronizer for the control inputs ui_in[3:0]
  logic [3:0] sync1;
  logic [3:0] sync2;
  // Previous synced level of the two set buttons, for rising-edge detect
  logic [1:0] btn_prev;

  logic          run;
  logic          fast;
  logic          min_set;
  logic          hour_set;
  logic          set_any;
  logic          tick;
  logic          sec_tick;
  logic [PW-1:0] prescaler;
  logic          presc_last;

  bin_time_t     now;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hour_wrap_unused;
  logic          min_inc;
  logic          hour_inc;
  logic [5:0]    disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      btn_prev <= '0;
    end else begin
      sync1    <= ui_in[3:0];
      sync2    <= sync1;
      btn_prev <= sync2[2:1];
    end
  end

  assign run      = sync2[0];
  assign fast     = sync2[3];
  assign min_set  = sync2[1] & ~btn_prev[0];
  assign hour_set = sync2[2] & ~btn_prev[1];
  assign set_any  = min_set | hour_set;

  assign presc_last = (prescaler == PW'(CLK_HZ - 1));
  assign tick       = run & (fast | presc_last);
  // A set edge owns the cycle: the tick that would have landed here is dropped
  assign sec_tick   = tick & ~set_any;

  // Min-set restarts the second, so the next tick is a full second later
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
    end else if (min_set) begin
      prescaler <= '0;
    end else if (run) begin
      prescaler <= presc_last ? '0 : prescaler + 1'b1;
    end
  end

  // Minute advances on a seconds carry or a min-set edge. A min-set
  // roll-over 59->0 must not carry into the hour, so only the tick-driven
  // wrap is forwarded; the two never coincide because set edges block ticks.
  assign min_inc  = sec_wrap | min_set;
  assign hour_inc = (min_wrap & ~min_set) | hour_set;

  mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk  (clk),
    .rst  (rst),
    .inc  (sec_tick),
    .clr  (min_set),
    .q    (now.sec),
    .wrap (sec_wrap)
  );

  mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (min_inc),
    .clr  (1'b0),
    .q    (now.min),
    .wrap (min_wrap)
  );

  mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk  (clk),
    .rst  (rst),
    .inc  (hour_inc),
    .clr  (1'b0),
    .q    (now.hour),
    .wrap (hour_wrap_unused)
  );

`ifdef DISPLAY_SEL_EN
  logic disp_sync1;
  logic disp_sync2;
  logic unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_sync1 <= 1'b0;
      disp_sync2 <= 1'b0;
    end else begin
      disp_sync1 <= ui_in[7];
      disp_sync2 <= disp_sync1;
    end
  end

  assign disp   = disp_sync2 ? now.sec : now.min;
  assign unused = &{1'b0, ena, uio_in, ui_in[6:4], hour_wrap_unused};
`else
  logic unused;

  assign disp   = now.min;
  assign unused = &{1'b0, ena, uio_in, ui_in[7:4], now.sec[5:1], hour_wrap_unused};
`endif

  assign uo_out  = {1'b0, now.sec[0], disp};
  assign uio_out = {3'b000, now.hour};
  assign uio_oe  = 8'h1F;

endmodule

// File: tb/tb_tt11_um_oblivioux.sv
// tb/tb_tt11_um_oblivioux.sv - self-checking bench for the binary wall clock tile
module tb_tt11_um_oblivioux;

  localparam int CLK_HZ = 4;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int errors;

  tt11_um_oblivioux #(.CLK_HZ(CLK_HZ)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: wall-clock time as hours/minutes/seconds integers, a
  // seconds phase counter, and a 3-deep history of ui_in sampled at edges
  // (h1 = last edge, h2 = two edges ago, h3 = three edges ago).
  int         m_hour;
  int         m_min;
  int         m_sec;
  int         m_phase;
  logic [7:0] h1, h2, h3;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic run, fast, mset, hset, tick;
    int   total;
    if (rst) begin
      m_hour = 0; m_min = 0; m_sec = 0; m_phase = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      run  = h2[0];
      fast = h2[3];
      mset = h2[1] && !h3[1];
      hset = h2[2] && !h3[2];
      tick = run && (fast || m_phase == CLK_HZ - 1);
      if (mset || hset) begin
        if (mset) begin
          m_min = (m_min + 1) % 60;
          m_sec = 0;
        end
        if (hset) m_hour = (m_hour + 1) % 24;
      end else if (tick) begin
        total  = (m_hour * 3600 + m_min * 60 + m_sec + 1) % 86400;
        m_hour = total / 3600;
        m_min  = (total / 60) % 60;
        m_sec  = total % 60;
      end
      if (mset) m_phase = 0;
      else if (run) m_phase = (m_phase + 1) % CLK_HZ;
      h3 = h2; h2 = h1; h1 = ui_in;
    end
  endtask

  function automatic int exp_uo();
    int shown;
`ifdef DISPLAY_SEL_EN
    shown = h2[7] ? m_sec : m_min;
`else
    shown = m_min;
`endif
    return ((m_sec % 2) << 6) | shown;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycles(input int n, input int every);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (every > 0 && (i % every) == every - 1) begin
        check("model_uo", uo_out, exp_uo());
        check("model_uio", uio_out, m_hour);
      end
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    ui_in = 8'h00;
    cycles(2, 0);
    rst   = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] base, input logic [7:0] btn, input int n);
    for (int i = 0; i < n; i++) begin
      ui_in = base | btn;
      cycles(5, 0);
      ui_in = base;
      cycles(5, 0);
    end
  endtask

  initial begin
    int   toggles;
    logic last6;
    checks = 0;
    errors = 0;
    ena    = 1'b1;
    uio_in = 8'h00;
    rst    = 1'b1;
    ui_in  = 8'h00;

    // 1: reset state
    #1;
    do_reset();
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'h1F);

    // 2: normal run, one minute = 60 * 4 cycles after the sync delay
    ui_in   = 8'h01;
    toggles = 0;
    last6   = uo_out[6];
    for (int i = 0; i < 242; i++) begin
      cycle();
      if (uo_out[6] != last6) toggles++;
      last6 = uo_out[6];
    end
    check("run_uo", uo_out, 8'h01);
    check("run_uio", uio_out, 8'h00);
    check("run_toggles", toggles, 60);
    check("run_model", uo_out, exp_uo());

    // 3: fast mode, one hour then a full day
    do_reset();
    ui_in = 8'h09;
    cycles(3602, 1024);
    check("fast_hour", uio_out, 8'h01);
    check("fast_min", uo_out[5:0], 0);
    cycles(86400 - 3600, 2048);
    check("day_uo", uo_out, 8'h00);
    check("day_uio", uio_out, 8'h00);

    // 4: set buttons with run=0
    do_reset();
    pulse(8'h00, 8'h02, 61);
    check("mset_min", uo_out[5:0], 1);
    check("mset_hour", uio_out, 8'h00);
    pulse(8'h00, 8'h04, 29);
    check("hset_hour", uio_out, 8'h05);
    check("hset_model", uo_out, exp_uo());

    // 5: min-set landing on a tick at 00:59:58 -> 00:00:00, no carry, no tick
    do_reset();
    pulse(8'h00, 8'h02, 59);
    ui_in = 8'h09;
    cycles(58, 0);
    check("pre_56", uo_out, 8'h3B);
    ui_in = 8'h0B;
    cycles(2, 0);
    check("pre_58", uo_out, 8'h3B);
    check("pre_58_sec", m_sec, 58);
    cycle();
    check("set_on_tick_uo", uo_out, 8'h00);
    check("set_on_tick_uio", uio_out, 8'h00);
    ui_in = 8'h00;
    cycles(4, 0);

    // 6: reset mid-run at 13:45:xx
    do_reset();
    pulse(8'h00, 8'h04, 13);
    pulse(8'h00, 8'h02, 45);
    ui_in = 8'h09;
    cycles(2 + $urandom_range(5, 50), 0);
    check("mid_hour", uio_out, 13);
    check("mid_min", uo_out[5:0], 45);
    rst = 1'b1;
    cycle();
    check("mid_rst_uo", uo_out, 8'h00);
    check("mid_rst_uio", uio_out, 8'h00);
    rst = 1'b0;
`ifdef DISPLAY_SEL_EN
    ui_in = 8'h89;
    cycles(40, 0);
    check("disp_sec", uo_out[5:0], m_sec);
`endif

    // Random stimulus against the model, checked every cycle
    for (int k = 0; k < 300; k++) begin
      ui_in = 8'($urandom) & 8'h8F;
      if ($urandom_range(0, 3) == 0) ui_in[3] = 1'b0;
      cycles($urandom_range(1, 8), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
